tile_query_arbiter: RTL
=======================

Name: tile_query_arbiter

Overview:
- Shares the single read port of the background tile RAM (12 rows x 17 cols of tile codes) between up to NUM_REQ movement controllers: Mario up/down, Mario left/right, and enemy movers.
- Arbitrates round-robin, sequences the RAM read, and returns the tile code to the granted requester.
- Coordinates outside the map resolve to BDR (border tile) without touching the RAM.
- Runs in the movement clock domain.

Parameters:
- NUM_REQ, 4: number of requesters.
- ROWS, 12: map rows.
- COLS, 17: map columns.
- ROW_W, 4: row index width.
- COL_W, 5: column index width.
- TILE_W, 8: tile code width.
- BDR, 0: tile code returned for out-of-range coordinates.

Ports:
- movement_clock, input, 1: block clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req, input, NUM_REQ: per-requester request level.
- req_row, input, NUM_REQ*ROW_W: packed row per requester; requester i uses bits [i*ROW_W +: ROW_W].
- req_col, input, NUM_REQ*COL_W: packed column per requester, packed the same way.
- gnt, output, NUM_REQ: one-cycle accept pulse, one-hot.
- rsp_valid, output, NUM_REQ: one-cycle response pulse, one-hot.
- rsp_tile, output, TILE_W: tile code; qualified by rsp_valid.
- busy, output, 1: high whenever state is not IDLE.
- ram_rd_en, output, 1: RAM read strobe.
- ram_row, output, ROW_W: RAM row address.
- ram_col, output, COL_W: RAM column address.
- ram_rd_data, input, TILE_W: RAM data, valid the cycle after ram_rd_en.
- map_wr, input, 1: pulse when the tile map is modified (e.g. a block is broken).

Behaviour:
- All outputs are registered.
- Reset values:
  - gnt, rsp_valid, ram_rd_en, busy = 0.
  - rsp_tile = BDR.
  - ram_row, ram_col = 0.
  - rr_ptr = 0.
  - state = IDLE.
- States: IDLE, READ, DATA, RESP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner w: the first set req bit scanning from rr_ptr upward, wrapping at NUM_REQ.
  - At that edge: gnt[w] <= 1; latch w, row and col; set oor = (row >= ROWS) || (col >= COLS).
  - If !oor: ram_rd_en <= 1, ram_row <= row, ram_col <= col.
  - Next state READ.
- READ: gnt <= 0, ram_rd_en <= 0; next state DATA.
- DATA: rsp_tile <= oor ? BDR : ram_rd_data; rsp_valid[w] <= 1; next state RESP.
- RESP: rsp_valid <= 0; rr_ptr <= (w+1) mod NUM_REQ; next state IDLE.
- Latency and throughput:
  - Grant edge = E. rsp_valid is high in the cycle following edge E+2.
  - The next grant can occur at edge E+4, giving a throughput of 1 query per 4 cycles.
  - The out-of-range path has identical timing, but ram_rd_en is never asserted.
- Handshake:
  - A requester holds req, row and col stable until its gnt pulse.
  - It may drop req after gnt.
  - To issue a new query, it re-asserts req no earlier than the cycle after its rsp_valid.
  - If req drops before grant, it is simply not considered; no response is produced.
- Fairness:
  - The last winner becomes lowest priority.
  - With all req held high, the grant order is 0,1,2,3,0,...
- Simultaneous requests: exactly one grant per transaction; the others wait with no loss.
- req changes during READ/DATA/RESP are ignored until IDLE.
- map_wr has no effect on an in-flight read in base mode.
- Reset mid-transaction:
  - The transaction is abandoned; no rsp_valid is emitted.
  - All outputs take their reset values immediately (asynchronous).
  - rr_ptr returns to 0.

Optional Feature:
- Macro: TILE_QUERY_CACHE_EN.
- Defined:
  - A single-entry cache holds {valid, row, col, tile} of the last completed in-range RAM read.
  - In IDLE, a winner whose row/col match a valid entry gets gnt[w] <= 1 and rsp_valid[w] <= 1 at the same edge, with rsp_tile <= cached tile and ram_rd_en held at 0. Next state is RESP.
  - A cache hit therefore answers 2 cycles earlier than a miss.
  - The cache is invalidated by map_wr (any state; a fill landing in the same cycle is discarded) and by reset.
  - Out-of-range lookups are never cached.
- Not defined:
  - No cache is built. Every in-range query reads RAM.
  - map_wr is ignored, but the port remains.

Test Plan:
- req=0001, row=9, col=3, RAM[9][3]=3 (GND) -> gnt[0] at edge 0; ram_rd_en=1 with ram_row=9, ram_col=3 for one cycle; rsp_valid[0]=1 with rsp_tile=3 after edge 2; busy low after edge 3.
- req=1111 held constant for 8 transactions -> gnt order 0,1,2,3,0,1,2,3; exactly one gnt per 4 cycles; no rsp_valid to an ungranted requester.
- req[2] with row=12, col=5 -> rsp_tile=0 (BDR), ram_rd_en never asserted, same 3-cycle latency; row=3, col=17 gives the same result.
- reset pulled low during DATA -> no rsp_valid; all outputs at reset values; next query with req=1010 grants requester 1 first.
- With TILE_QUERY_CACHE_EN: two queries to (4,7) -> the second is granted and answered at the same edge with no ram_rd_en. A map_wr pulse then a third query to (4,7) -> a full RAM read, returning the new RAM value 2 (BLK).
- req[1] dropped one cycle before it would win against a held req[3] -> requester 3 granted; requester 1 gets no gnt or rsp_valid.

Source files
------------

// File: rtl/tile_query_arbiter.sv
// Round-robin arbiter sharing the tile RAM read port among movement controllers.
// Optional single-entry result cache enabled by defining TILE_QUERY_CACHE_EN.
module tile_query_arbiter #(
    parameter int unsigned       NUM_REQ = 4,
    parameter int unsigned       ROWS    = 12,
    parameter int unsigned       COLS    = 17,
    parameter int unsigned       ROW_W   = 4,
    parameter int unsigned       COL_W   = 5,
    parameter int unsigned       TILE_W  = 8,
    parameter logic [TILE_W-1:0] BDR     = '0
) (
    input  logic                     movement_clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ROW_W-1:0] req_row,
    input  logic [NUM_REQ*COL_W-1:0] req_col,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [TILE_W-1:0]        rsp_tile,
    output logic                     busy,
    output logic                     ram_rd_en,
    output logic [ROW_W-1:0]         ram_row,
    output logic [COL_W-1:0]         ram_col,
    input  logic [TILE_W-1:0]        ram_rd_data,
    input  logic                     map_wr
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StData, StResp} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      w_q, w_d;
    logic                  oor_q, oor_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [TILE_W-1:0]     rsp_tile_q, rsp_tile_d;
    logic                  busy_q, busy_d;
    logic                  ram_rd_en_q, ram_rd_en_d;
    logic [ROW_W-1:0]      ram_row_q, ram_row_d;
    logic [COL_W-1:0]      ram_col_q, ram_col_d;

    logic                  any_req;
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      cand;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;
    logic                  win_oor;
    logic                  cache_hit;

    // First set request at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    assign win_row = req_row[int'(win)*ROW_W +: ROW_W];
    assign win_col = req_col[int'(win)*COL_W +: COL_W];
    assign win_oor = ({1'b0, win_row} >= (ROW_W+1)'(ROWS)) ||
                     ({1'b0, win_col} >= (COL_W+1)'(COLS));

`ifdef TILE_QUERY_CACHE_EN
    logic              cache_valid_q, cache_valid_d;
    logic [ROW_W-1:0]  cache_row_q, cache_row_d;
    logic [COL_W-1:0]  cache_col_q, cache_col_d;
    logic [TILE_W-1:0] cache_tile_q, cache_tile_d;

    // A map write in the same cycle would make the cached tile stale.
    assign cache_hit = cache_valid_q && !map_wr && !win_oor &&
                       (cache_row_q == win_row) && (cache_col_q == win_col);
`else
    logic unused_map_wr;
    assign unused_map_wr = map_wr;
    assign cache_hit     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        w_d         = w_q;
        oor_d       = oor_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        ram_rd_en_d = 1'b0;
        rsp_tile_d  = rsp_tile_q;
        ram_row_d   = ram_row_q;
        ram_col_d   = ram_col_q;
`ifdef TILE_QUERY_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_row_d   = cache_row_q;
        cache_col_d   = cache_col_q;
        cache_tile_d  = cache_tile_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_d[win] = 1'b1;
                    w_d        = win;
                    oor_d      = win_oor;
                    if (cache_hit) begin
                        rsp_valid_d[win] = 1'b1;
`ifdef TILE_QUERY_CACHE_EN
                        rsp_tile_d       = cache_tile_q;
`endif
                        state_d          = StResp;
                    end else begin
                        if (!win_oor) begin
                            ram_rd_en_d = 1'b1;
                            ram_row_d   = win_row;
                            ram_col_d   = win_col;
                        end
                        state_d = StRead;
                    end
                end
            end
            StRead: state_d = StData;
            StData: begin
                rsp_tile_d       = oor_q ? BDR : ram_rd_data;
                rsp_valid_d[w_q] = 1'b1;
`ifdef TILE_QUERY_CACHE_EN
                if (!oor_q) begin
                    cache_valid_d = 1'b1;
                    cache_row_d   = ram_row_q;
                    cache_col_d   = ram_col_q;
                    cache_tile_d  = ram_rd_data;
                end
`endif
                state_d = StResp;
            end
            StResp: begin
                rr_ptr_d = (w_q == PTR_W'(NUM_REQ - 1)) ? '0 : w_q + PTR_W'(1);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef TILE_QUERY_CACHE_EN
        if (map_wr) cache_valid_d = 1'b0;
`endif
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            w_q         <= '0;
            oor_q       <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_tile_q  <= BDR;
            busy_q      <= 1'b0;
            ram_rd_en_q <= 1'b0;
            ram_row_q   <= '0;
            ram_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            w_q         <= w_d;
            oor_q       <= oor_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tile_q  <= rsp_tile_d;
            busy_q      <= busy_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_row_q   <= ram_row_d;
            ram_col_q   <= ram_col_d;
        end
    end

`ifdef TILE_QUERY_CACHE_EN
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_row_q   <= '0;
            cache_col_q   <= '0;
            cache_tile_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_row_q   <= cache_row_d;
            cache_col_q   <= cache_col_d;
            cache_tile_q  <= cache_tile_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tile  = rsp_tile_q;
    assign busy      = busy_q;
    assign ram_rd_en = ram_rd_en_q;
    assign ram_row   = ram_row_q;
    assign ram_col   = ram_col_q;

endmodule
